// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Datapath control bundle between the multicycle control unit (master) and
// the MIPS-subset datapath (slave).
//   Instruction : instruction word from instruction memory (datapath -> ctrl)
//   RegWr, RegDst, ExtOp, ALUsrc, ALUctr[2:0], MemWr, MemtoReg,
//   Branch, Jump, PCWr, IRWr : datapath controls (ctrl -> datapath)
//   state[2:0], halted, retired[RET_W-1:0] : status (ctrl -> datapath)
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int RET_W = 32
);
    logic [31:0]      Instruction;
    logic             RegWr;
    logic             RegDst;
    logic             ExtOp;
    logic             ALUsrc;
    logic [2:0]       ALUctr;
    logic             MemWr;
    logic             MemtoReg;
    logic             Branch;
    logic             Jump;
    logic             PCWr;
    logic             IRWr;
    logic [2:0]       state;
    logic             halted;
    logic [RET_W-1:0] retired;

    modport master (
        input  Instruction,
        output RegWr, RegDst, ExtOp, ALUsrc, ALUctr, MemWr, MemtoReg,
               Branch, Jump, PCWr, IRWr, state, halted, retired
    );

    modport slave (
        output Instruction,
        input  RegWr, RegDst, ExtOp, ALUsrc, ALUctr, MemWr, MemtoReg,
               Branch, Jump, PCWr, IRWr, state, halted, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control unit for the MIPS-subset datapath. Each instruction is
// walked through FETCH/DECODE/EXEC/MEM/WB; every write strobe fires for
// exactly one cycle per instruction. Also counts retired instructions and
// halts on an illegal opcode (or treats it as a NOP).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : multicycle_ctrl_if.master (Instruction in; controls/status out)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int RET_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       reg_wr;
        logic       reg_dst;
        logic       ext_op;
        logic       alu_src;
        logic [2:0] alu_ctr;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       pc_wr;
        logic       ir_wr;
        logic       halted;
    } ctrl_t;

    state_t           state_q, state_n;
    logic [5:0]       op_q, op_n, funct_q, funct_n;
    ctrl_t            ctrl_q, ctrl_n;
    logic [RET_W-1:0] retired_q;

    // Only opcode and funct fields matter to control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.Instruction[25:6];

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b101010, 6'b101011: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] alu_op(input logic [5:0] op, input logic [5:0] funct);
        logic [2:0] a;
        a = 3'b000;
        case (op)
            OP_R: begin
                case (funct)
                    6'b100000: a = 3'b100;  // add
                    6'b100001: a = 3'b000;  // addu
                    6'b100010: a = 3'b101;  // sub
                    6'b100011: a = 3'b001;  // subu
                    6'b100100: a = 3'b011;  // and
                    6'b100101: a = 3'b010;  // or
                    6'b101010: a = 3'b111;  // slt
                    6'b101011: a = 3'b110;  // sltu
                    default:   a = 3'b000;
                endcase
            end
            OP_ORI:  a = 3'b010;
            OP_BEQ:  a = 3'b001;
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    // Next state and the op/funct latch. FETCH only advances once IRWr is
    // actually visible, so the first cycle after reset shows no strobes.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        funct_n = funct_q;
        case (state_q)
            FETCH: begin
                if (ctrl_q.ir_wr) begin
                    op_n    = bus.Instruction[31:26];
                    funct_n = bus.Instruction[5:0];
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (!is_legal(op_q, funct_q))
                    state_n = HALT_ON_ILLEGAL ? HALT : FETCH;
                else if (op_q == OP_J)
                    state_n = FETCH;
                else
                    state_n = EXEC;
            end
            EXEC: begin
                if (op_q == OP_BEQ)
                    state_n = FETCH;
                else if (op_q == OP_LW || op_q == OP_SW)
                    state_n = MEM;
                else
                    state_n = WB;
            end
            MEM:     state_n = (op_q == OP_SW) ? FETCH : WB;
            WB:      state_n = FETCH;
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered and
    // line up with the state they belong to.
    always_comb begin
        ctrl_n = '0;
        case (state_n)
            FETCH: ctrl_n.ir_wr = 1'b1;
            DECODE: begin
                if (!is_legal(op_n, funct_n)) begin
                    ctrl_n.pc_wr = !HALT_ON_ILLEGAL;
                end else if (op_n == OP_J) begin
                    ctrl_n.jump  = 1'b1;
                    ctrl_n.pc_wr = 1'b1;
                end
            end
            EXEC, MEM, WB: begin
                // Mux/ALU controls are held across EXEC, MEM and WB.
                ctrl_n.reg_dst = (op_n == OP_R);
                ctrl_n.ext_op  = (op_n == OP_ADDIU) || (op_n == OP_LW) || (op_n == OP_SW);
                ctrl_n.alu_src = (op_n == OP_ORI) || ctrl_n.ext_op;
                ctrl_n.alu_ctr = alu_op(op_n, funct_n);
                if (state_n == EXEC && op_n == OP_BEQ) begin
                    ctrl_n.branch = 1'b1;
                    ctrl_n.pc_wr  = 1'b1;
                end
                if (state_n == MEM) begin
                    ctrl_n.mem_wr     = (op_n == OP_SW);
                    ctrl_n.pc_wr      = (op_n == OP_SW);
                    ctrl_n.mem_to_reg = (op_n == OP_LW);
                end
                if (state_n == WB) begin
                    ctrl_n.reg_wr     = 1'b1;
                    ctrl_n.pc_wr      = 1'b1;
                    ctrl_n.mem_to_reg = (op_n == OP_LW);
                end
            end
            HALT:    ctrl_n.halted = 1'b1;
            default: ctrl_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            funct_q   <= '0;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            funct_q   <= funct_n;
            ctrl_q    <= ctrl_n;
            // A commit counts once its PCWr cycle completes.
            retired_q <= retired_q + RET_W'(ctrl_q.pc_wr);
        end
    end

    assign bus.RegWr    = ctrl_q.reg_wr;
    assign bus.RegDst   = ctrl_q.reg_dst;
    assign bus.ExtOp    = ctrl_q.ext_op;
    assign bus.ALUsrc   = ctrl_q.alu_src;
    assign bus.ALUctr   = ctrl_q.alu_ctr;
    assign bus.MemWr    = ctrl_q.mem_wr;
    assign bus.MemtoReg = ctrl_q.mem_to_reg;
    assign bus.Branch   = ctrl_q.branch;
    assign bus.Jump     = ctrl_q.jump;
    assign bus.PCWr     = ctrl_q.pc_wr;
    assign bus.IRWr     = ctrl_q.ir_wr;
    assign bus.state    = state_q;
    assign bus.halted   = ctrl_q.halted;
    assign bus.retired  = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit for the team's MIPS-subset datapath; the driving end of the datapath control interface (RegWr, RegDst, ExtOp, ALUsrc, ALUctr, MemWr, MemtoReg, Branch, Jump).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and asserts each write strobe for exactly one cycle per instruction.
- Adds PCWr/IRWr strobes so the datapath PC and IR update only on commit/fetch.
- Also provides a retired-instruction counter and an illegal-opcode halt.

Parameters:
- RET_W, 32, width of retired-instruction counter.
- HALT_ON_ILLEGAL, 1: 1 = illegal op/funct enters HALT; 0 = treated as NOP (commits in DECODE).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Instruction  in  32  instruction word from instruction memory; sampled only when IRWr=1.
- RegWr  out  1  register-file write enable.
- RegDst  out  1  0=Rt, 1=Rd as write register.
- ExtOp  out  1  0=zero-extend, 1=sign-extend imm16.
- ALUsrc  out  1  0=busB, 1=extended immediate.
- ALUctr  out  3  ALU operation: 000 ADDU, 001 SUBU, 010 OR, 011 AND, 100 ADD, 101 SUB, 110 SLTU, 111 SLT.
- MemWr  out  1  data-memory write enable.
- MemtoReg  out  1  0=ALU result, 1=memory data to busW.
- Branch  out  1  beq PC select; valid while PCWr=1.
- Jump  out  1  j PC select; valid while PCWr=1.
- PCWr  out  1  PC update strobe (instruction commit).
- IRWr  out  1  IR load strobe.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- halted  out  1  1 while in HALT.
- retired  out  RET_W  count of PCWr pulses.

Behaviour:
- Reset (async, immediate): state=FETCH, internal op/funct latch=0, retired=0, halted=0, all control outputs 0. Outputs remain deasserted until the first rising edge after reset release.
- Outputs are Moore: decoded from state plus latched op[5:0]/funct[5:0]. Registered, glitch-free; no combinational path from Instruction to any output.
- FETCH: IRWr=1; Instruction[31:26] and Instruction[5:0] latched at the edge; next state DECODE.
- Supported ops: R-type op=000000 with funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010, sltu 101011; plus ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010.
- DECODE: illegal op/funct -> HALT (or NOP commit if HALT_ON_ILLEGAL=0). j: Jump=1, PCWr=1 -> FETCH. All others -> EXEC.
- EXEC:
  - R-type: RegDst=1, ALUsrc=0, ALUctr per funct -> WB.
  - ori: ExtOp=0, ALUsrc=1, ALUctr=OR -> WB.
  - addiu: ExtOp=1, ALUsrc=1, ALUctr=ADDU -> WB.
  - lw/sw: ExtOp=1, ALUsrc=1, ALUctr=ADDU -> MEM.
  - beq: ALUsrc=0, ALUctr=SUBU, Branch=1, PCWr=1 -> FETCH.
- MEM:
  - Address controls are held from EXEC.
  - sw: MemWr=1, PCWr=1 -> FETCH.
  - lw: MemtoReg=1 -> WB.
- WB:
  - Mux/ALU controls are held from EXEC (and MemtoReg for lw).
  - RegWr=1 and PCWr=1 (one cycle) -> FETCH.
- Outside their strobe state, RegWr, MemWr, PCWr, IRWr, Branch and Jump are 0.
- Latency in cycles, FETCH through commit: j 2; beq 3; sw 4; R/ori/addiu 4; lw 5.
- retired increments by 1 on every cycle with PCWr=1, including NOP commits. Wraps modulo 2^RET_W with no flag.
- HALT: all strobes 0 and halted=1 until reset; Instruction is ignored.
- Reset mid-instruction: any pending write is abandoned, with no RegWr/MemWr/PCWr pulse. Restart is at FETCH.
- Instruction changing outside FETCH has no effect on outputs.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) -> IRWr at cycle 0; EXEC RegDst=1, ALUctr=000; WB RegWr=PCWr=1; retired=1 after 4 cycles.
- lw 0x8C220004 then sw 0xAC220008 -> lw takes 5 cycles with MemtoReg=1, RegWr in WB only; sw takes 4 cycles with MemWr=1 for exactly 1 cycle, RegWr never 1; retired=2.
- beq 0x10220003 then j 0x08000010 -> beq takes 3 cycles, Branch=PCWr=1 in EXEC with ALUctr=001; j takes 2 cycles with Jump=PCWr=1 in DECODE.
- Illegal op 0xFC000000, HALT_ON_ILLEGAL=1 -> state=7, halted=1, no strobes for 20 cycles; reset returns to FETCH with retired=0. Repeat with HALT_ON_ILLEGAL=0 -> PCWr in DECODE, retired increments.
- Assert reset during WB of ori 0x34220FFF -> RegWr/PCWr drop immediately (asynchronously), state=0; the instruction is not retired.
- RET_W=4, run 17 addiu -> retired wraps to 1; slt funct 101010 -> ALUctr=111; sltu -> 110.
